// File: rtl/writeback_pipe.sv
// Writeback stage: formats the selected result and queues it in a small FIFO feeding the register-file write port.
// Optional macro WB_LOAD_EXT_EN enables byte/half/word load extraction and sign/zero extension.
module writeback_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       data_read_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       pcsrc_i,
  input  logic [XLEN-1:0]       offset_i,
  input  logic [1:0]            mem_to_reg_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            byte_off_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  reg_write_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [XLEN-1:0]       data_write_reg_o,
  input  logic                  rf_ready_i,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]       fwd_data_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [XLEN-1:0]       data_mem_r [DEPTH];
  logic [REG_ADDR_W-1:0] rd_mem_r   [DEPTH];
  logic                  we_mem_r   [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  head_valid_s;
  logic                  rf_we_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ready_s;
  logic [XLEN-1:0]       load_data_s;
  logic [XLEN-1:0]       wb_data_s;
  logic                  fwd_valid_s;
  logic [REG_ADDR_W-1:0] fwd_addr_s;
  logic [XLEN-1:0]       fwd_data_s;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return {PTR_W{1'b0}};
    else                      return p + PTR_W'(1);
  endfunction

`ifdef WB_LOAD_EXT_EN
  // Extract the addressed byte/half/word and extend it according to the load type.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [2:0] f3,
                                               input logic [1:0] bo);
    logic [XLEN-1:0] sh;
    sh = raw >> {bo, 3'b000};
    case (f3)
      3'b000:  return XLEN'($signed(sh[7:0]));
      3'b001:  return XLEN'($signed(sh[15:0]));
      3'b100:  return XLEN'(sh[7:0]);
      3'b101:  return XLEN'(sh[15:0]);
      3'b110:  return XLEN'(sh[31:0]);
      3'b011:  return sh;
      default: return XLEN'($signed(sh[31:0]));
    endcase
  endfunction

  assign load_data_s = load_ext(data_read_i, funct3_i, byte_off_i);
`else
  logic unused_s;
  assign unused_s    = ^{funct3_i, byte_off_i};
  assign load_data_s = data_read_i;
`endif

  // Writeback source selection.
  always_comb begin
    wb_data_s = alu_result_i;
    case (mem_to_reg_i)
      2'b00:   wb_data_s = alu_result_i;
      2'b01:   wb_data_s = load_data_s;
      2'b10:   wb_data_s = pcsrc_i;
      2'b11:   wb_data_s = offset_i;
      default: wb_data_s = alu_result_i;
    endcase
  end

  // Head retire and upstream handshake; non-writing heads drain without a port grant.
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    rf_we_s      = head_valid_s & we_mem_r[rd_ptr_r] & (rd_mem_r[rd_ptr_r] != {REG_ADDR_W{1'b0}});
    pop_s        = head_valid_s & (rf_ready_i | ~rf_we_s);
    ready_s      = reset_i & ((count_r < CNT_W'(DEPTH)) | pop_s);
    push_s       = valid_i & ready_s;
  end

  // Forward the youngest buffered writing entry: walk oldest to youngest, last hit wins.
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    logic             hit_s;
    fwd_valid_s = 1'b0;
    fwd_addr_s  = {REG_ADDR_W{1'b0}};
    fwd_data_s  = {XLEN{1'b0}};
    idx_s       = rd_ptr_r;
    for (int k = 0; k < DEPTH; k++) begin
      hit_s       = (CNT_W'(k) < count_r) & we_mem_r[idx_s] & (rd_mem_r[idx_s] != {REG_ADDR_W{1'b0}});
      fwd_valid_s = fwd_valid_s | hit_s;
      fwd_addr_s  = hit_s ? rd_mem_r[idx_s] : fwd_addr_s;
      fwd_data_s  = hit_s ? data_mem_r[idx_s] : fwd_data_s;
      idx_s       = ptr_inc(idx_s);
    end
  end

  // Buffer storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {XLEN{1'b0}};
        rd_mem_r[i]   <= {REG_ADDR_W{1'b0}};
        we_mem_r[i]   <= 1'b0;
      end
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= wb_data_s;
        rd_mem_r[wr_ptr_r]   <= rd_i;
        we_mem_r[wr_ptr_r]   <= reg_write_i;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign ready_o          = ready_s;
  assign rf_we_o          = rf_we_s;
  assign rf_addr_o        = head_valid_s ? rd_mem_r[rd_ptr_r] : {REG_ADDR_W{1'b0}};
  assign data_write_reg_o = head_valid_s ? data_mem_r[rd_ptr_r] : {XLEN{1'b0}};
  assign fwd_valid_o      = fwd_valid_s;
  assign fwd_addr_o       = fwd_addr_s;
  assign fwd_data_o       = fwd_data_s;
  assign count_o          = count_r;

endmodule

// File: tb/tb_writeback_pipe.sv
// Self-checking bench for writeback_pipe (DEPTH=2, XLEN=32) using a queue scoreboard of expected buffer entries.
module tb_writeback_pipe;
  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] data_read_i, alu_result_i, pcsrc_i, offset_i;
  logic [1:0]      mem_to_reg_i;
  logic [2:0]      funct3_i;
  logic [1:0]      byte_off_i;
  logic [RAW-1:0]  rd_i;
  logic            reg_write_i;
  logic            rf_we_o;
  logic [RAW-1:0]  rf_addr_o;
  logic [XLEN-1:0] data_write_reg_o;
  logic            rf_ready_i;
  logic            fwd_valid_o;
  logic [RAW-1:0]  fwd_addr_o;
  logic [XLEN-1:0] fwd_data_o;
  logic [1:0]      count_o;

  typedef struct packed {
    logic            we;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  writeback_pipe #(.XLEN(XLEN), .REG_ADDR_W(RAW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_read_i(data_read_i), .alu_result_i(alu_result_i), .pcsrc_i(pcsrc_i),
    .offset_i(offset_i), .mem_to_reg_i(mem_to_reg_i), .funct3_i(funct3_i),
    .byte_off_i(byte_off_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .data_write_reg_o(data_write_reg_o),
    .rf_ready_i(rf_ready_i), .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
    .fwd_data_o(fwd_data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference formatting, written as explicit byte/half selection.
  function automatic logic [31:0] model_fmt(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [31:0] pc,
                                            input logic [31:0] off, input logic [2:0] f3,
                                            input logic [1:0] bo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = mem[bo*8 +: 8];
    h = (bo == 2'd3) ? {8'h00, mem[31:24]} : mem[bo*8 +: 16];
    case (sel)
      2'b00: r = alu;
      2'b10: r = pc;
      2'b11: r = off;
      default: begin
`ifdef WB_LOAD_EXT_EN
        case (f3)
          3'b000:  r = {{24{b[7]}}, b};
          3'b001:  r = {{16{h[15]}}, h};
          3'b100:  r = {24'h000000, b};
          3'b101:  r = {16'h0000, h};
          default: r = mem >> (bo * 8);
        endcase
`else
        r = mem;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard monitor: compare outputs to model, then advance model by the upcoming edge.
  always @(negedge clk_i) begin
    ent_t            hd;
    logic            exp_pop, exp_ready, hd_we, fv;
    logic [RAW-1:0]  fa;
    logic [XLEN-1:0] fd;
    if (!reset_i) begin
      chk("rst_we", rf_we_o, 1'b0);
      chk("rst_addr", rf_addr_o, 5'd0);
      chk("rst_data", data_write_reg_o, 32'd0);
      chk("rst_fwd", {fwd_valid_o, fwd_addr_o, fwd_data_o}, 38'd0);
      chk("rst_count", count_o, 2'd0);
      chk("rst_ready", ready_o, 1'b0);
      exp_q.delete();
    end else begin
      chk("count", count_o, exp_q.size());
      if (exp_q.size() == 0) begin
        chk("empty_we", rf_we_o, 1'b0);
        chk("empty_addr", rf_addr_o, 5'd0);
        chk("empty_data", data_write_reg_o, 32'd0);
        exp_pop = 1'b0;
      end else begin
        hd    = exp_q[0];
        hd_we = hd.we && (hd.rd != 5'd0);
        chk("head_we", rf_we_o, hd_we);
        chk("head_addr", rf_addr_o, hd.rd);
        chk("head_data", data_write_reg_o, hd.data);
        exp_pop = rf_ready_i || !hd_we;
      end
      fv = 1'b0; fa = 5'd0; fd = 32'd0;
      foreach (exp_q[i]) begin
        if (exp_q[i].we && exp_q[i].rd != 5'd0) begin
          fv = 1'b1; fa = exp_q[i].rd; fd = exp_q[i].data;
        end
      end
      chk("fwd_valid", fwd_valid_o, fv);
      chk("fwd_addr", fwd_addr_o, fa);
      chk("fwd_data", fwd_data_o, fd);
      exp_ready = (exp_q.size() < DEPTH) || exp_pop;
      chk("ready", ready_o, exp_ready);
      if (exp_pop) void'(exp_q.pop_front());
      if (valid_i && exp_ready)
        exp_q.push_back('{we: reg_write_i, rd: rd_i,
                          data: model_fmt(mem_to_reg_i, alu_result_i, data_read_i, pcsrc_i,
                                          offset_i, funct3_i, byte_off_i)});
    end
  end

  // Drive one transfer and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [31:0] val, input logic [2:0] f3,
                      input logic [1:0] bo, input logic [4:0] rd, input logic we);
    logic acc;
    int   n;
    alu_result_i = $urandom; data_read_i = $urandom; pcsrc_i = $urandom; offset_i = $urandom;
    case (sel)
      2'b00:   alu_result_i = val;
      2'b01:   data_read_i  = val;
      2'b10:   pcsrc_i      = val;
      default: offset_i     = val;
    endcase
    mem_to_reg_i = sel; funct3_i = f3; byte_off_i = bo; rd_i = rd; reg_write_i = we;
    valid_i = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    valid_i = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0; valid_i = 1'b0; rf_ready_i = 1'b0;
    data_read_i = '0; alu_result_i = '0; pcsrc_i = '0; offset_i = '0;
    mem_to_reg_i = 2'b00; funct3_i = 3'b000; byte_off_i = 2'b00; rd_i = '0; reg_write_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", ready_o, 1'b1);
    @(posedge clk_i); #1;

    // Basic ALU writeback latency
    rf_ready_i = 1'b1;
    send(2'b00, 32'h0000_1234, 3'b000, 2'b00, 5'd5, 1'b1);
    chk("alu_we", rf_we_o, 1'b1);
    chk("alu_addr", rf_addr_o, 5'd5);
    chk("alu_data", data_write_reg_o, 32'h0000_1234);
    chk("alu_count", count_o, 2'd1);

    // Each source select
    send(2'b10, 32'hCAFE_0004, 3'b010, 2'b00, 5'd1, 1'b1);
    send(2'b11, 32'hFFFF_FFF0, 3'b010, 2'b00, 5'd31, 1'b1);
    send(2'b01, 32'h1357_9BDF, 3'b010, 2'b00, 5'd7, 1'b1);

    // Load formatting
    send(2'b01, 32'h80FF_7F01, 3'b000, 2'd3, 5'd9, 1'b1);
`ifdef WB_LOAD_EXT_EN
    chk("lb_off3", data_write_reg_o, 32'hFFFF_FF80);
`else
    chk("lb_off3_raw", data_write_reg_o, 32'h80FF_7F01);
`endif
    send(2'b01, 32'h80FF_7F01, 3'b101, 2'd2, 5'd10, 1'b1);
`ifdef WB_LOAD_EXT_EN
    chk("lhu_off2", data_write_reg_o, 32'h0000_80FF);
`else
    chk("lhu_off2_raw", data_write_reg_o, 32'h80FF_7F01);
`endif
    send(2'b01, 32'h0000_8001, 3'b001, 2'd0, 5'd11, 1'b1);
    send(2'b01, 32'h1234_5678, 3'b100, 2'd1, 5'd12, 1'b1);

    // Fill while port is busy, then release
    @(posedge clk_i); #1;
    rf_ready_i = 1'b0;
    send(2'b00, 32'hA000_0001, 3'b000, 2'd0, 5'd2, 1'b1);
    send(2'b00, 32'hA000_0002, 3'b000, 2'd0, 5'd3, 1'b1);
    chk("full_ready", ready_o, 1'b0);
    chk("full_count", count_o, 2'd2);
    fork
      send(2'b00, 32'hA000_0003, 3'b000, 2'd0, 5'd4, 1'b1);
      begin
        repeat (3) @(posedge clk_i);
        #1 rf_ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk_i); #1;

    // rd=0 with write enable drains without the port
    rf_ready_i = 1'b0;
    send(2'b00, 32'hDEAD_BEEF, 3'b000, 2'd0, 5'd0, 1'b1);
    chk("rd0_we", rf_we_o, 1'b0);
    chk("rd0_fwd", fwd_valid_o, 1'b0);
    chk("rd0_count", count_o, 2'd1);
    @(posedge clk_i); #1;
    chk("rd0_retired", count_o, 2'd0);

    // Randomized traffic
    for (int c = 0; c < 120; c++) begin
      valid_i      = 1'($urandom_range(0, 1));
      rf_ready_i   = 1'($urandom_range(0, 1));
      mem_to_reg_i = 2'($urandom);
      funct3_i     = 3'($urandom);
      byte_off_i   = 2'($urandom);
      rd_i         = 5'($urandom_range(0, 3));
      reg_write_i  = 1'($urandom);
      data_read_i  = $urandom; alu_result_i = $urandom; pcsrc_i = $urandom; offset_i = $urandom;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    rf_ready_i = 1'b1;
    repeat (4) @(posedge clk_i); #1;

    // Reset in the middle of a full buffer
    rf_ready_i = 1'b0;
    send(2'b00, 32'hB000_0001, 3'b000, 2'd0, 5'd6, 1'b1);
    send(2'b00, 32'hB000_0002, 3'b000, 2'd0, 5'd8, 1'b1);
    chk("pre_rst_count", count_o, 2'd2);
    #2 reset_i = 1'b0;
    #1;
    chk("midrst_we", rf_we_o, 1'b0);
    chk("midrst_addr", rf_addr_o, 5'd0);
    chk("midrst_data", data_write_reg_o, 32'd0);
    chk("midrst_fwd", fwd_valid_o, 1'b0);
    chk("midrst_count", count_o, 2'd0);
    chk("midrst_ready", ready_o, 1'b0);
    @(posedge clk_i); #1 reset_i = 1'b1;
    rf_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rel_ready", ready_o, 1'b1);
    chk("rel_we", rf_we_o, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
